// File: rtl/game_timer_pkg.sv
// Shared types and digit limits for the game stopwatch.
// Imported by bcd_digit_counter and game_timer_bcd.
package game_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUNNING   = 2'd1,
    ST_STOPPED   = 2'd2,
    ST_SATURATED = 2'd3
  } state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX        = 4'd9;
  localparam bcd_digit_t SEC_DOZENS_MAX = 4'd7;

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit: counts 0..MAX on inc and wraps to 0.
// carry is combinational so a whole cascade advances in a single clock.
module bcd_digit_counter
  import game_timer_pkg::*;
#(
  parameter bcd_digit_t MAX = BCD_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output bcd_digit_t digit,
  output logic       carry
);

  bcd_digit_t digit_q, digit_d;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    digit_d = digit_q;
    if (inc) begin
      digit_d = (digit_q == MAX) ? '0 : digit_q + 4'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;
  assign carry = inc && (digit_q == MAX);

endmodule

// File: rtl/game_timer_bcd.sv
// Game stopwatch in packed BCD (ss.hh), saturating at 79.99 s.
// Optional GAME_TIMER_LIMIT_EN: saturate and pulse time_up on reaching LIMIT_SEC.00.
module game_timer_bcd
  import game_timer_pkg::*;
#(
  parameter int CLK_HZ    = 40_000_000,
  parameter int TICK_HZ   = 100,
  parameter int LIMIT_SEC = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [6:0] seconds_dozens_unity,
  output logic [7:0] hundredths_of_second,
  output logic       running,
  output logic       overflow,
  output logic       time_up
);

  localparam int            DIV        = CLK_HZ / TICK_HZ;
  localparam int            PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;

  bcd_digit_t h_unity, h_dozens, s_unity, s_dozens;
  logic       c_hu, c_hd, c_su, c_sd;
  logic       tick, at_max, advance, limit_hit;

  assign tick   = (state_q == ST_RUNNING) && (presc_q == PRESC_LAST);
  assign at_max = (s_dozens == SEC_DOZENS_MAX) && (s_unity == BCD_MAX) &&
                  (h_dozens == BCD_MAX) && (h_unity == BCD_MAX);
  // A stop or clear in the tick cycle wins, and 79.99 never rolls over.
  assign advance = tick && !stop && !clear && !at_max;

`ifdef GAME_TIMER_LIMIT_EN
  localparam bcd_digit_t LIM_SD = bcd_digit_t'((LIMIT_SEC - 1) / 10);
  localparam bcd_digit_t LIM_SU = bcd_digit_t'((LIMIT_SEC - 1) % 10);

  logic time_up_q;

  // The increment out of (LIMIT-1).99 lands exactly on LIMIT.00.
  assign limit_hit = advance && (s_dozens == LIM_SD) && (s_unity == LIM_SU) &&
                     (h_dozens == BCD_MAX) && (h_unity == BCD_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      time_up_q <= 1'b0;
    end else begin
      time_up_q <= limit_hit;
    end
  end

  assign time_up = time_up_q;
`else
  logic [31:0] unused_limit;

  assign limit_hit    = 1'b0;
  assign time_up      = 1'b0;
  assign unused_limit = LIMIT_SEC;
`endif

  bcd_digit_counter #(.MAX(BCD_MAX)) u_h_unity (
    .clk(clk), .rst(rst), .clr(clear), .inc(advance), .digit(h_unity), .carry(c_hu)
  );
  bcd_digit_counter #(.MAX(BCD_MAX)) u_h_dozens (
    .clk(clk), .rst(rst), .clr(clear), .inc(c_hu), .digit(h_dozens), .carry(c_hd)
  );
  bcd_digit_counter #(.MAX(BCD_MAX)) u_s_unity (
    .clk(clk), .rst(rst), .clr(clear), .inc(c_hd), .digit(s_unity), .carry(c_su)
  );
  bcd_digit_counter #(.MAX(SEC_DOZENS_MAX)) u_s_dozens (
    .clk(clk), .rst(rst), .clr(clear), .inc(c_su), .digit(s_dozens), .carry(c_sd)
  );

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    if (clear) begin
      state_d = ST_IDLE;
      presc_d = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_STOPPED: begin
          if (start && !stop) begin
            state_d = ST_RUNNING;
            presc_d = '0;
          end
        end
        ST_RUNNING: begin
          presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
          if (stop) begin
            state_d = ST_STOPPED;
          end else if (tick && (at_max || limit_hit)) begin
            state_d = ST_SATURATED;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
    end
  end

  // s_dozens never exceeds 7, so its top bit and the final carry carry no information.
  logic unused_bits;
  assign unused_bits = ^{c_sd, s_dozens[3]};

  assign seconds_dozens_unity = {s_dozens[2:0], s_unity};
  assign hundredths_of_second = {h_dozens, h_unity};
  assign running              = (state_q == ST_RUNNING);
  assign overflow             = (state_q == ST_SATURATED);

endmodule

// File: tb/tb_game_timer_bcd.sv
// Self-checking bench for game_timer_bcd at DIV=4; the reference model keeps time
// as an integer count of hundredths. Limit scenario runs when GAME_TIMER_LIMIT_EN is defined.
module tb_game_timer_bcd;

  localparam int CLK_HZ    = 400;
  localparam int TICK_HZ   = 100;
  localparam int DIV       = CLK_HZ / TICK_HZ;
  localparam int LIMIT_SEC = 2;
`ifdef GAME_TIMER_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2, M_SAT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic [6:0] seconds_dozens_unity;
  logic [7:0] hundredths_of_second;
  logic       running;
  logic       overflow;
  logic       time_up;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: elapsed hundredths, mode, cycles since the last tick.
  int m_cnt = 0;
  int m_st  = M_IDLE;
  int m_pre = 0;
  bit m_tu  = 1'b0;

  game_timer_bcd #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .LIMIT_SEC(LIMIT_SEC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .seconds_dozens_unity(seconds_dozens_unity),
    .hundredths_of_second(hundredths_of_second),
    .running(running), .overflow(overflow), .time_up(time_up)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] exp_sec();
    int s = m_cnt / 100;
    return {3'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [7:0] exp_hun();
    int h = m_cnt % 100;
    return {4'(h / 10), 4'(h % 10)};
  endfunction

  task automatic model_edge(input bit s, input bit p, input bit c, input bit r);
    bit tk;
    m_tu = 1'b0;
    if (r || c) begin
      m_cnt = 0;
      m_st  = M_IDLE;
      m_pre = 0;
    end else if (m_st == M_IDLE || m_st == M_STOP) begin
      if (s && !p) begin
        m_st  = M_RUN;
        m_pre = 0;
      end
    end else if (m_st == M_RUN) begin
      tk    = (m_pre == DIV - 1);
      m_pre = tk ? 0 : m_pre + 1;
      if (p) begin
        m_st = M_STOP;
      end else if (tk) begin
        if (m_cnt == 7999) begin
          m_st = M_SAT;
        end else begin
          m_cnt++;
          if (LIMIT_EN && m_cnt == LIMIT_SEC * 100) begin
            m_st = M_SAT;
            m_tu = 1'b1;
          end
        end
      end
    end
  endtask

  // One clock: inputs applied before the edge, model advanced, outputs settle by #1.
  task automatic step(input bit s, input bit p, input bit c, input bit r);
    start = s;
    stop  = p;
    clear = c;
    rst   = r;
    @(posedge clk);
    model_edge(s, p, c, r);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    clear = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (seconds_dozens_unity !== 7'h00) begin
      n_fail++; $display("FAIL reset_sec: got %h expected %h", seconds_dozens_unity, 7'h00);
    end
    n_tests++;
    if (hundredths_of_second !== 8'h00) begin
      n_fail++; $display("FAIL reset_hun: got %h expected %h", hundredths_of_second, 8'h00);
    end
    n_tests++;
    if ({running, overflow, time_up} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {running, overflow, time_up});
    end
  endtask

  task automatic test_count_seconds();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(100 * DIV);
    n_tests++;
    if (seconds_dozens_unity !== 7'h01 || seconds_dozens_unity !== exp_sec()) begin
      n_fail++; $display("FAIL one_second_sec: got %h expected %h", seconds_dozens_unity, exp_sec());
    end
    n_tests++;
    if (hundredths_of_second !== 8'h00 || running !== 1'b1) begin
      n_fail++; $display("FAIL one_second_hun_run: got %h/%b expected 00/1", hundredths_of_second, running);
    end
  endtask

  task automatic test_stop_resume();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(37 * DIV);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(200);
    n_tests++;
    if (hundredths_of_second !== 8'h37 || running !== 1'b0) begin
      n_fail++; $display("FAIL stop_hold: got %h/%b expected 37/0", hundredths_of_second, running);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(5 * DIV);
    n_tests++;
    if (hundredths_of_second !== 8'h42 || hundredths_of_second !== exp_hun()) begin
      n_fail++; $display("FAIL resume: got %h expected %h", hundredths_of_second, exp_hun());
    end
  endtask

  task automatic test_saturate();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(7999 * DIV);
    n_tests++;
    if ({seconds_dozens_unity, hundredths_of_second, overflow} !== {7'h79, 8'h99, 1'b0}) begin
      n_fail++; $display("FAIL at_7999: got %h.%h ovf=%b expected 79.99 ovf=0",
                         seconds_dozens_unity, hundredths_of_second, overflow);
    end
    idle(DIV);
    n_tests++;
    if ({seconds_dozens_unity, hundredths_of_second, overflow, running} !== {7'h79, 8'h99, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL saturated: got %h.%h ovf=%b run=%b expected 79.99 ovf=1 run=0",
                         seconds_dozens_unity, hundredths_of_second, overflow, running);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    n_tests++;
    if (running !== 1'b0 || overflow !== 1'b1 || hundredths_of_second !== 8'h99) begin
      n_fail++; $display("FAIL sat_ignores_start: got run=%b ovf=%b hun=%h expected 0/1/99",
                         running, overflow, hundredths_of_second);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if ({seconds_dozens_unity, hundredths_of_second, running, overflow} !== {7'h00, 8'h00, 2'b00}) begin
      n_fail++; $display("FAIL sat_clear: got %h.%h run=%b ovf=%b expected 00.00 0/0",
                         seconds_dozens_unity, hundredths_of_second, running, overflow);
    end
  endtask

  task automatic test_clear_and_corners();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(15 * DIV);
    n_tests++;
    if (hundredths_of_second !== 8'h15) begin
      n_fail++; $display("FAIL pre_clear: got %h expected 15", hundredths_of_second);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if ({seconds_dozens_unity, hundredths_of_second, running} !== {7'h00, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL run_clear: got %h.%h run=%b expected 00.00 run=0",
                         seconds_dozens_unity, hundredths_of_second, running);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(DIV);
    n_tests++;
    if (running !== 1'b0 || hundredths_of_second !== 8'h00) begin
      n_fail++; $display("FAIL start_stop_same: got run=%b hun=%h expected 0/00", running, hundredths_of_second);
    end
    // Three full ticks then DIV-1 cycles: the next edge is a tick edge, and stop lands on it.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3 * DIV + DIV - 1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    n_tests++;
    if (hundredths_of_second !== 8'h03 || running !== 1'b0) begin
      n_fail++; $display("FAIL stop_on_tick: got %h run=%b expected 03 run=0", hundredths_of_second, running);
    end
  endtask

  task automatic test_limit();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(200 * DIV - 1);
    n_tests++;
    if (time_up !== 1'b0 || hundredths_of_second !== 8'h99) begin
      n_fail++; $display("FAIL pre_limit: got time_up=%b hun=%h expected 0/99", time_up, hundredths_of_second);
    end
    idle(1);
    n_tests++;
    if ({seconds_dozens_unity, hundredths_of_second, time_up, overflow} !== {7'h02, 8'h00, 2'b11}) begin
      n_fail++; $display("FAIL limit_hit: got %h.%h tu=%b ovf=%b expected 02.00 1/1",
                         seconds_dozens_unity, hundredths_of_second, time_up, overflow);
    end
    idle(1);
    n_tests++;
    if (time_up !== 1'b0) begin
      n_fail++; $display("FAIL time_up_width: got %b expected 0", time_up);
    end
    idle(3 * DIV);
    n_tests++;
    if ({seconds_dozens_unity, hundredths_of_second, overflow} !== {7'h02, 8'h00, 1'b1}) begin
      n_fail++; $display("FAIL limit_hold: got %h.%h ovf=%b expected 02.00 1",
                         seconds_dozens_unity, hundredths_of_second, overflow);
    end
  endtask

  task automatic test_random();
    bit s, p, c, r;
    int shown = 0;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4000; i++) begin
      s = ($urandom_range(0, 99) < 6);
      p = ($urandom_range(0, 99) < 2);
      c = ($urandom_range(0, 999) < 3);
      r = ($urandom_range(0, 999) < 2);
      step(s, p, c, r);
      n_tests++;
      if (seconds_dozens_unity !== exp_sec() || hundredths_of_second !== exp_hun() ||
          running !== (m_st == M_RUN) || overflow !== (m_st == M_SAT) || time_up !== m_tu) begin
        n_fail++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random cycle %0d: got %h.%h r%b o%b t%b expected %h.%h r%b o%b t%b", i,
                   seconds_dozens_unity, hundredths_of_second, running, overflow, time_up,
                   exp_sec(), exp_hun(), m_st == M_RUN, m_st == M_SAT, m_tu);
        end
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_count_seconds();
    test_stop_resume();
`ifndef GAME_TIMER_LIMIT_EN
    test_saturate();
`endif
    test_clear_and_corners();
`ifdef GAME_TIMER_LIMIT_EN
    test_limit();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_timer_bcd.md
Name: game_timer_bcd

Overview:
- Game stopwatch feeding the end-of-game text ROM with packed BCD time: seconds as {dozens[2:0], unity[3:0]}, hundredths as {dozens[3:0], unity[3:0]}.
- Counts in 10 ms steps from a prescaled system clock.
- Started and stopped by the game-control FSM; frozen value is displayed on the result screen.
- Saturates at 79.99 s, the maximum the 3-bit seconds-dozens field can show.

Parameters:
- CLK_HZ, 40_000_000, system clock frequency in Hz.
- TICK_HZ, 100, increment rate in Hz (hundredths of a second).
- DIV, CLK_HZ/TICK_HZ (derived localparam), prescaler period in clk cycles; must be ≥2.
- LIMIT_SEC, 60, time limit in whole seconds (1..79); used only with GAME_TIMER_LIMIT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begin or resume counting.
- stop  in  1  single-cycle pulse; freeze count.
- clear  in  1  single-cycle pulse; zero count, return to IDLE.
- seconds_dozens_unity  out  7  {s_dozens[2:0], s_unity[3:0]}, BCD.
- hundredths_of_second  out  8  {h_dozens[3:0], h_unity[3:0]}, BCD.
- running  out  1  high in RUNNING.
- overflow  out  1  high in SATURATED.
- time_up  out  1  one-cycle pulse on reaching the limit (GAME_TIMER_LIMIT_EN only).

Behaviour:
- Interface: single clock clk; reset rst is synchronous, active-high. Everything else is sampled on posedge clk.
- Reset and clear: all outputs 0, prescaler 0, state IDLE. rst and clear act identically; clear is honoured in any state.
- States:
  - IDLE: count 00.00.
  - RUNNING.
  - STOPPED: count held.
  - SATURATED: count held at its final value.
- Transitions:
  - IDLE/STOPPED + start → RUNNING; prescaler cleared on entry.
  - RUNNING + stop → STOPPED.
  - RUNNING, tick at 79.99 → SATURATED.
  - Any state + clear → IDLE.
  - SATURATED exits only on clear or rst; start and stop are ignored there.
  - start in RUNNING is ignored.
- Priority: rst > clear > stop > start > tick. start and stop in the same cycle from IDLE/STOPPED leave the state unchanged. A stop coinciding with a tick suppresses that increment.
- Prescaler:
  - Width $clog2(DIV).
  - Counts 0..DIV-1 only in RUNNING; tick when value is DIV-1, then wraps to 0.
  - Holds its value outside RUNNING.
  - First tick after start occurs DIV cycles after the start edge.
- BCD cascade on tick:
  - h_unity 0..9; at 9 → 0 and carry into h_dozens.
  - h_dozens 0..9; at 9 → 0 and carry into s_unity.
  - s_unity 0..9; at 9 → 0 and carry into s_dozens.
  - s_dozens 0..7.
  - Any tick at 79.99 leaves the count at 79.99 and sets the state to SATURATED, so overflow=1 on the next cycle.
  - Digits never leave 0..9 (s_dozens 0..7).
- Latency: outputs are registered and reflect a tick one cycle after the tick cycle. running/overflow change on the edge that changes the state.

Optional Feature:
- Macro GAME_TIMER_LIMIT_EN.
- Defined:
  - When a tick brings the count to LIMIT_SEC.00, the state becomes SATURATED.
  - time_up pulses high for exactly one cycle, aligned with that output update.
  - overflow goes high.
- Undefined: time_up tied 0; LIMIT_SEC unused; saturation only at 79.99.

Decomposition:
- Package game_timer_pkg:
  - state enum (IDLE, RUNNING, STOPPED, SATURATED).
  - 4-bit BCD digit typedef.
  - constants: BCD_MAX=9, SEC_DOZENS_MAX=7.
- Sub-module bcd_digit_counter, instantiated four times:
  - parameter MAX;
  - inputs clk, rst, clr, inc;
  - outputs digit, carry (combinational, = inc && digit==MAX).
  - Saturation hold is gated in the parent by suppressing inc.

Test Plan (sim with CLK_HZ=400, TICK_HZ=100, so DIV=4):
1. rst held 2 cycles → seconds_dozens_unity=7'h00, hundredths_of_second=8'h00, running=0, overflow=0, time_up=0.
2. start pulse, wait 100 ticks (400 cycles +1) → 7'h01 / 8'h00, running=1.
3. start, 37 ticks, stop, wait 200 cycles → 8'h37 held, running=0. start, 5 ticks → 8'h42.
4. start, 7999 ticks → 7'h79 / 8'h99, overflow=0. One more tick → unchanged, overflow=1. start → no effect. clear → 00.00, IDLE.
5. RUNNING at 8'h15 + clear → next cycle 7'h00/8'h00, running=0. Same-cycle start+stop from IDLE → running stays 0. Stop on a tick cycle → count unchanged.
6. With GAME_TIMER_LIMIT_EN and LIMIT_SEC=2: start, 200 ticks → 7'h02 / 8'h00, time_up high exactly one cycle, overflow=1. Further cycles → count holds.
